// File: rtl/ld_updn_counter_mod.sv
// Parametrised loadable up/down modulo counter with synchronous clear,
// combinational cascade carry/borrow and a registered terminal-count pulse.
module ld_updn_counter_mod #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAXV    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SCLR,
  input  logic             SP,
  input  logic             LD,
  input  logic             UP,
  input  logic             CI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             TCP
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tcp_q;
  logic             tcp_d;
  logic [WIDTH:0]   top_diff_s;
  logic             at_top_s;
  logic             at_zero_s;

  // A borrow-free subtraction means cnt_q >= MAXV; this also covers values
  // loaded above MAXV, which must wrap to zero on the next up-count.
  assign top_diff_s = {1'b0, cnt_q} - {1'b0, MAXV};
  assign at_top_s   = ~top_diff_s[WIDTH];
  assign at_zero_s  = (cnt_q == ZERO_C);

  // Next-state selection following clear > enable > load > count priority
  always_comb begin
    cnt_d = cnt_q;
    tcp_d = 1'b0;
    if (SCLR) begin
      cnt_d = ZERO_C;
    end else if (!SP) begin
      cnt_d = cnt_q;
    end else if (LD) begin
      cnt_d = D;
    end else if (CI) begin
      if (UP) begin
        if (at_top_s) begin
          cnt_d = ZERO_C;
          tcp_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end else begin
        if (at_zero_s) begin
          cnt_d = MAXV;
          tcp_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and terminal-count pulse registers with asynchronous reset
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      cnt_q <= RST_VAL;
      tcp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tcp_q <= tcp_d;
    end
  end

  // Carry ignores SP and LD so a stalled lower stage still presents its carry
  assign CO  = CI & (UP ? at_top_s : at_zero_s);
  assign Q   = cnt_q;
  assign TCP = tcp_q;

endmodule

// File: tb/tb_ld_updn_counter_mod.sv
// Self-checking bench for ld_updn_counter_mod: directed vector table, async
// reset and cascade sequences, and randomized runs against a reference model.
module tb_ld_updn_counter_mod;

  logic       ck;
  logic       cd, sclr, sp, ld, up, ci;
  logic [3:0] d;

  logic [3:0] a_q;
  logic       a_co, a_tcp;
  logic [2:0] z_q;
  logic       z_co, z_tcp;
  logic [0:0] t_q;
  logic       t_co, t_tcp;

  logic       c_cd, c_sp, c_ci;
  logic [3:0] lo_q, hi_q;
  logic       lo_co, lo_tcp, hi_co, hi_tcp;

  int checks = 0;
  int errors = 0;

  ld_updn_counter_mod #(.WIDTH(4), .MAXV(4'd9), .RST_VAL(4'd3)) u_a (
    .CK(ck), .CD(cd), .SCLR(sclr), .SP(sp), .LD(ld), .UP(up), .CI(ci),
    .D(d), .Q(a_q), .CO(a_co), .TCP(a_tcp));

  ld_updn_counter_mod #(.WIDTH(3), .MAXV(3'd0), .RST_VAL(3'd0)) u_z (
    .CK(ck), .CD(cd), .SCLR(sclr), .SP(sp), .LD(ld), .UP(up), .CI(ci),
    .D(d[2:0]), .Q(z_q), .CO(z_co), .TCP(z_tcp));

  ld_updn_counter_mod #(.WIDTH(1), .MAXV(1'b1), .RST_VAL(1'b0)) u_t (
    .CK(ck), .CD(cd), .SCLR(sclr), .SP(sp), .LD(ld), .UP(up), .CI(ci),
    .D(d[0:0]), .Q(t_q), .CO(t_co), .TCP(t_tcp));

  ld_updn_counter_mod u_lo (
    .CK(ck), .CD(c_cd), .SCLR(1'b0), .SP(c_sp), .LD(1'b0), .UP(1'b1), .CI(c_ci),
    .D(4'd0), .Q(lo_q), .CO(lo_co), .TCP(lo_tcp));

  ld_updn_counter_mod u_hi (
    .CK(ck), .CD(c_cd), .SCLR(1'b0), .SP(c_sp), .LD(1'b0), .UP(1'b1), .CI(lo_co),
    .D(4'd0), .Q(hi_q), .CO(hi_co), .TCP(hi_tcp));

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Reference model for the three shared-input instances: index 0 = u_a, 1 = u_z, 2 = u_t
  localparam int MAXV_M [3] = '{9, 0, 1};
  localparam int RST_M  [3] = '{3, 0, 0};
  localparam int SIZE_M [3] = '{16, 8, 2};
  int mq [3];
  bit mt [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = RST_M[k];
      mt[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      mt[k] = 1'b0;
      if (cd) begin
        mq[k] = RST_M[k];
      end else if (sclr) begin
        mq[k] = 0;
      end else if (!sp) begin
        mq[k] = mq[k];
      end else if (ld) begin
        mq[k] = int'(d) % SIZE_M[k];
      end else if (ci && up) begin
        if (mq[k] >= MAXV_M[k]) begin mq[k] = 0; mt[k] = 1'b1; end
        else mq[k] = mq[k] + 1;
      end else if (ci) begin
        if (mq[k] == 0) begin mq[k] = MAXV_M[k]; mt[k] = 1'b1; end
        else mq[k] = mq[k] - 1;
      end
    end
  endtask

  function automatic logic model_co(int k);
    return ci & (up ? (mq[k] >= MAXV_M[k]) : (mq[k] == 0));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    model_update();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_a_q"}, 32'(a_q), mq[0]);
    chk({tag, "_a_tcp"}, 32'(a_tcp), 32'(mt[0]));
    chk({tag, "_a_co"}, 32'(a_co), 32'(model_co(0)));
    chk({tag, "_z_q"}, 32'(z_q), mq[1]);
    chk({tag, "_z_tcp"}, 32'(z_tcp), 32'(mt[1]));
    chk({tag, "_z_co"}, 32'(z_co), 32'(model_co(1)));
    chk({tag, "_t_q"}, 32'(t_q), mq[2]);
    chk({tag, "_t_tcp"}, 32'(t_tcp), 32'(mt[2]));
    chk({tag, "_t_co"}, 32'(t_co), 32'(model_co(2)));
  endtask

  typedef struct {
    logic       sclr, sp, ld, up, ci;
    logic [3:0] d;
    int         q;
    logic       tcp, co;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input logic s, input logic p, input logic l, input logic u,
                     input logic c, input logic [3:0] dv, input int q,
                     input logic tc, input logic co);
    vec_t v;
    v = '{s, p, l, u, c, dv, q, tc, co};
    tbl.push_back(v);
  endtask

  int exp_v;
  int hi_pulses;

  initial begin
    cd = 1'b1; sclr = 1'b0; sp = 1'b1; ld = 1'b0; up = 1'b1; ci = 1'b1; d = 4'd0;
    c_cd = 1'b1; c_sp = 1'b1; c_ci = 1'b1;
    model_reset();

    // Vectors applied from Q=4 (the value left by the async-reset sequence)
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, k, 1'b0, k == 9);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 9, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 5, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 12, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 9, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 9, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 12, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 11, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 11, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 11, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1'b0, 1'b0);

    // Reset state and carry from the reset value
    #2;
    chk("rst_a_q", 32'(a_q), 32'd3);
    chk("rst_a_tcp", 32'(a_tcp), 32'd0);
    chk("rst_a_co", 32'(a_co), 32'd0);
    chk("rst_z_co", 32'(z_co), 32'd1);
    tick();
    chk("cd_edge_no_count", 32'(a_q), 32'd3);
    cd = 1'b0; ld = 1'b1; d = 4'd7;
    tick();
    chk("load7", 32'(a_q), 32'd7);
    ld = 1'b0;
    #3;
    cd = 1'b1;
    model_reset();
    #1;
    chk("async_rst_q", 32'(a_q), 32'd3);
    chk("async_rst_tcp", 32'(a_tcp), 32'd0);
    #1;
    cd = 1'b0;
    tick();
    chk("post_rst_count", 32'(a_q), 32'd4);

    for (int i = 0; i < tbl.size(); i++) begin
      sclr = tbl[i].sclr; sp = tbl[i].sp; ld = tbl[i].ld;
      up = tbl[i].up; ci = tbl[i].ci; d = tbl[i].d;
      tick();
      chk($sformatf("vec%0d_q", i), 32'(a_q), tbl[i].q);
      chk($sformatf("vec%0d_tcp", i), 32'(a_tcp), 32'(tbl[i].tcp));
      chk($sformatf("vec%0d_co", i), 32'(a_co), 32'(tbl[i].co));
    end

    // Randomized run against the model, including async resets and out-of-range loads
    for (int i = 0; i < 1500; i++) begin
      tick();
      chk_model($sformatf("rnd%0d", i));
      cd   = ($urandom % 64) == 0;
      sclr = ($urandom % 20) == 0;
      sp   = ($urandom % 8) != 0;
      ld   = ($urandom % 10) == 0;
      up   = $urandom % 2;
      ci   = ($urandom % 4) != 0;
      d    = 4'($urandom % 16);
      if (cd) model_reset();
      #1;
      chk($sformatf("rnd%0d_async_a_q", i), 32'(a_q), mq[0]);
      chk($sformatf("rnd%0d_comb_a_co", i), 32'(a_co), 32'(model_co(0)));
      chk($sformatf("rnd%0d_comb_z_co", i), 32'(z_co), 32'(model_co(1)));
      chk($sformatf("rnd%0d_comb_t_co", i), 32'(t_co), 32'(model_co(2)));
    end
    cd = 1'b0;

    // Two-stage cascade: 8-bit count with a mid-run stall
    c_cd = 1'b0; c_sp = 1'b1; c_ci = 1'b1;
    hi_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      exp_v = (i + 1) % 256;
      chk($sformatf("casc%0d_val", i), 32'({hi_q, lo_q}), exp_v);
      chk($sformatf("casc%0d_hi_tcp", i), 32'(hi_tcp), 32'(exp_v == 0));
      if (hi_tcp === 1'b1) hi_pulses++;
      if (i == 100) begin
        c_sp = 1'b0;
        repeat (3) begin
          tick();
          chk("casc_stall_val", 32'({hi_q, lo_q}), exp_v);
          chk("casc_stall_tcp", 32'({hi_tcp, lo_tcp}), 32'd0);
        end
        c_sp = 1'b1;
      end
    end
    chk("casc_hi_pulses", 32'(hi_pulses), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
